historico_ataques: RTL
======================

# historico_ataques

Attack-history recorder downstream of the attack manager in the battleship game. Each confirmed attack's coordinate and hit/miss result is logged into a circular buffer, with running attack and hit totals. Repeated or out-of-range shots are rejected. The player can step back through past shots with the debounced button; the browsed entry feeds the 7-segment display path.

## Interface
Parameters:
- PROFUNDIDADE, 8: number of buffered entries; power of two, 2..16.
- TOTAL_W, 8: width of the saturating totals.

Ports:
- clock_in  in  1  system clock (divided game clock); all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high during ATAQUE state; write and browse events are ignored while low.
- limpar  in  1  synchronous clear pulse, issued on entry to PREPARACAO.
- ataque_valido  in  1  single-cycle pulse: attack confirmed this cycle.
- coluna  in  3  attack column, valid range 0..4.
- linha  in  3  attack row, valid range 0..6.
- acerto  in  1  hit flag for this attack, sampled with ataque_valido.
- navegar  in  1  single-cycle pulse from level_to_pulse: step to the next-older entry.
- duplicado  out  1  one-cycle pulse: the cell was already attacked; nothing recorded.
- invalido  out  1  one-cycle pulse: coordinate out of range; nothing recorded.
- hist_coluna  out  3  column of the browsed entry.
- hist_linha  out  3  row of the browsed entry.
- hist_acerto  out  1  hit flag of the browsed entry.
- hist_valido  out  1  high when the buffer holds at least one entry.
- hist_indice  out  $clog2(PROFUNDIDADE)  browse distance (0 = newest).
- cheio  out  1  buffer holds PROFUNDIDADE entries.
- total_ataques  out  TOTAL_W  accepted attacks, saturating.
- total_acertos  out  TOTAL_W  accepted hits, saturating.

## Operation
- State:
  - wr_ptr: next write slot.
  - cont: valid entry count, 0..PROFUNDIDADE.
  - indice: browse distance.
  - visitados: 35-bit map of attacked cells, bit = linha*5 + coluna.
  - totals.
- Event priority per cycle: limpar > ataque_valido > navegar.
- limpar: clears all state exactly as reset does, regardless of enable.
- Attack, when ataque_valido & enable:
  - coluna > 4 or linha > 6: pulse invalido; no other change.
  - Cell already set in visitados: pulse duplicado; no other change.
  - Otherwise (accept):
    - mem[wr_ptr] ← {coluna, linha, acerto}; wr_ptr increments mod PROFUNDIDADE.
    - cont increments, saturating at PROFUNDIDADE. When full, the oldest entry is overwritten.
    - Set the cell's visitados bit.
    - total_ataques increments; total_acertos increments if acerto. Both saturate at all-ones.
    - indice ← 0.
- Browse, when navegar & enable and no accepted/rejected attack this cycle:
  - cont = 0: indice stays 0.
  - Otherwise indice ← (indice+1) mod cont, wrapping from oldest back to newest.
- Browsed entry: read slot = (wr_ptr − 1 − indice) mod PROFUNDIDADE.
- hist_valido = (cont ≠ 0). When hist_valido is low, hist_coluna, hist_linha and hist_acerto are 0.
- cheio = (cont == PROFUNDIDADE).

## Timing
- Reset (async assert, sync release): every output is 0, all pointers are 0, visitados is clear.
- duplicado and invalido are registered: asserted exactly one cycle after the ataque_valido cycle, for one cycle.
- hist_* outputs are registered. They reflect a write, a navegar step or a limpar one cycle after the event. There are no combinational paths from inputs to outputs.
- Totals, cheio and hist_indice update on the same edge that captures the event.
- Back-to-back ataque_valido on consecutive cycles must be handled. visitados is updated on the accepting edge, so a second identical coordinate on the next cycle is flagged duplicado.

## Configuration
- HISTORICO_DUPLICADO_EN:
  - Defined: visitados exists and duplicate rejection operates as above.
  - Undefined: visitados is not built and duplicado is tied 0. Every in-range attack is recorded and counted, including repeats. invalido checking is unchanged.

## Structure
- Package historico_pkg holds:
  - COLUNAS = 5 and LINHAS = 7.
  - Coordinate widths.
  - Typedef entrada_t {coluna[2:0], linha[2:0], acerto}.
- Sub-module mapa_visitados: a 35-bit test-and-set map with ports clock_in, reset_n, limpar, coluna, linha, testar, marcar and ja_visitado. It is instantiated only under HISTORICO_DUPLICADO_EN.

## Test plan
- Reset, then three accepted attacks (1,2,hit), (4,6,miss), (0,0,hit):
  - totals = 3 and 2, hist = (0,0,1), hist_indice = 0.
  - Two navegar pulses → hist = (1,2,1), hist_indice = 2; a third navegar wraps to hist_indice = 0.
- Attack (3,5), then (3,5) again → second attempt gives a duplicado pulse one cycle later; total_ataques stays 1.
- Attack coluna = 5 or linha = 7 → invalido pulse one cycle later; cont and totals unchanged.
- Nine distinct accepted attacks with PROFUNDIDADE = 8:
  - cheio = 1, total_ataques = 9.
  - Seven navegar pulses reach the 2nd attack; the 1st attack is unreachable.
- Simultaneous ataque_valido and navegar → attack accepted, hist_indice = 0. Then limpar mid-sequence → all outputs return to reset values the next cycle.
- With enable = 0, pulse ataque_valido and navegar → no output changes.

Source files
------------

// File: rtl/historico_pkg.sv
// historico_pkg: board geometry, coordinate widths and the history entry
// type shared by the attack-history recorder and its visited-cell map.
package historico_pkg;

   localparam int COLUNAS = 5;
   localparam int LINHAS  = 7;
   localparam int CELULAS = COLUNAS * LINHAS;

   localparam int COL_W = 3;
   localparam int LIN_W = 3;
   localparam int CEL_W = 6;

   typedef struct packed {
      logic [COL_W-1:0] coluna;
      logic [LIN_W-1:0] linha;
      logic             acerto;
   } entrada_t;

   // Linear cell number, linha*COLUNAS + coluna (wide enough for any 3-bit pair).
   function automatic logic [CEL_W-1:0] celula(input logic [COL_W-1:0] c,
                                               input logic [LIN_W-1:0] l);
      logic [CEL_W-1:0] cw;
      logic [CEL_W-1:0] lw;
      cw = {{(CEL_W-COL_W){1'b0}}, c};
      lw = {{(CEL_W-LIN_W){1'b0}}, l};
      return (lw * CEL_W'(COLUNAS)) + cw;
   endfunction

endpackage

// File: rtl/mapa_visitados.sv
// mapa_visitados: one flag per board cell. ja_visitado reports the current
// flag of the addressed cell while testar is high; marcar sets it on the edge.
module mapa_visitados
   import historico_pkg::*;
(
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             limpar,
   input  logic [COL_W-1:0] coluna,
   input  logic [LIN_W-1:0] linha,
   input  logic             testar,
   input  logic             marcar,
   output logic             ja_visitado
);

   logic [CELULAS-1:0] mapa_reg;
   logic [CELULAS-1:0] sel;
   logic [CEL_W-1:0]   idx;

   assign idx = celula(coluna, linha);

   genvar gi;
   generate
      for (gi = 0; gi < CELULAS; gi++) begin : g_cel
         assign sel[gi] = (idx == CEL_W'(gi));

         // Per-cell sticky flag, cleared by reset or limpar.
         always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n)
               mapa_reg[gi] <= 1'b0;
            else if (limpar)
               mapa_reg[gi] <= 1'b0;
            else if (marcar && sel[gi])
               mapa_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   // Out-of-board indices select no cell, so they never read as visited.
   assign ja_visitado = testar & (|(mapa_reg & sel));

endmodule

// File: rtl/historico_ataques.sv
// historico_ataques: circular log of accepted attacks with saturating totals
// and a browse pointer for the display path.
// Optional feature macro: HISTORICO_DUPLICADO_EN (builds the visited-cell map
// and rejects repeated shots; undefined means repeats are recorded normally).
module historico_ataques
   import historico_pkg::*;
#(
   parameter int PROFUNDIDADE = 8,
   parameter int TOTAL_W      = 8
)(
   input  logic                            clock_in,
   input  logic                            reset_n,
   input  logic                            enable,
   input  logic                            limpar,
   input  logic                            ataque_valido,
   input  logic [COL_W-1:0]                coluna,
   input  logic [LIN_W-1:0]                linha,
   input  logic                            acerto,
   input  logic                            navegar,
   output logic                            duplicado,
   output logic                            invalido,
   output logic [COL_W-1:0]                hist_coluna,
   output logic [LIN_W-1:0]                hist_linha,
   output logic                            hist_acerto,
   output logic                            hist_valido,
   output logic [$clog2(PROFUNDIDADE)-1:0] hist_indice,
   output logic                            cheio,
   output logic [TOTAL_W-1:0]              total_ataques,
   output logic [TOTAL_W-1:0]              total_acertos
);

   localparam int            IW       = $clog2(PROFUNDIDADE);
   localparam logic [IW:0]   CONT_MAX = (IW+1)'(PROFUNDIDADE);

   entrada_t            mem [PROFUNDIDADE];

   logic [IW-1:0]       wr_ptr_reg, wr_ptr_next;
   logic [IW:0]         cont_reg, cont_next;
   logic [IW-1:0]       indice_reg, indice_next;
   logic [IW:0]         indice_inc;
   logic [TOTAL_W-1:0]  tot_at_reg, tot_at_next;
   logic [TOTAL_W-1:0]  tot_ac_reg, tot_ac_next;
   logic                dup_reg, dup_next;
   logic                inv_reg, inv_next;
   entrada_t            hist_reg;
   entrada_t            entrada_in;
   logic [IW-1:0]       rd_addr;

   logic                ataque_ev;
   logic                fora;
   logic                repetido;
   logic                aceito;
   logic                navega;

   assign entrada_in.coluna = coluna;
   assign entrada_in.linha  = linha;
   assign entrada_in.acerto = acerto;

   assign ataque_ev = ataque_valido & enable;
   assign fora      = (coluna >= COL_W'(COLUNAS)) || (linha >= LIN_W'(LINHAS));

`ifdef HISTORICO_DUPLICADO_EN
   mapa_visitados u_mapa (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .limpar      (limpar),
      .coluna      (coluna),
      .linha       (linha),
      .testar      (ataque_ev & ~fora),
      .marcar      (aceito),
      .ja_visitado (repetido)
   );
`else
   assign repetido = 1'b0;
`endif

   assign aceito     = ~limpar & ataque_ev & ~fora & ~repetido;
   assign navega     = ~limpar & ~ataque_ev & navegar & enable & (cont_reg != '0);
   assign indice_inc = {1'b0, indice_reg} + 1'b1;

   // Next-state for pointers, totals and rejection pulses (limpar > attack > browse).
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      cont_next   = cont_reg;
      indice_next = indice_reg;
      tot_at_next = tot_at_reg;
      tot_ac_next = tot_ac_reg;
      dup_next    = 1'b0;
      inv_next    = 1'b0;
      if (limpar) begin
         wr_ptr_next = '0;
         cont_next   = '0;
         indice_next = '0;
         tot_at_next = '0;
         tot_ac_next = '0;
      end else if (ataque_ev) begin
         if (fora) begin
            inv_next = 1'b1;
         end else if (repetido) begin
            dup_next = 1'b1;
         end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (cont_reg != CONT_MAX)
               cont_next = cont_reg + 1'b1;
            indice_next = '0;
            if (~&tot_at_reg)
               tot_at_next = tot_at_reg + 1'b1;
            if (acerto && (~&tot_ac_reg))
               tot_ac_next = tot_ac_reg + 1'b1;
         end
      end else if (navega) begin
         indice_next = (indice_inc >= cont_reg) ? '0 : indice_inc[IW-1:0];
      end
   end

   // Slot the display will show after this edge: newest minus browse distance.
   assign rd_addr = wr_ptr_next - IW'(1) - indice_next;

   // State registers.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         cont_reg   <= '0;
         indice_reg <= '0;
         tot_at_reg <= '0;
         tot_ac_reg <= '0;
         dup_reg    <= 1'b0;
         inv_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         cont_reg   <= cont_next;
         indice_reg <= indice_next;
         tot_at_reg <= tot_at_next;
         tot_ac_reg <= tot_ac_next;
         dup_reg    <= dup_next;
         inv_reg    <= inv_next;
      end
   end

   // Entry storage; no reset so it maps onto block RAM.
   always_ff @(posedge clock_in) begin
      if (aceito)
         mem[wr_ptr_reg] <= entrada_in;
   end

   // Registered browse output; a fresh write is forwarded since it is the newest.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n)
         hist_reg <= '0;
      else if (limpar)
         hist_reg <= '0;
      else if (aceito)
         hist_reg <= entrada_in;
      else if (navega)
         hist_reg <= mem[rd_addr];
   end

   assign hist_valido   = (cont_reg != '0);
   assign hist_coluna   = hist_valido ? hist_reg.coluna : '0;
   assign hist_linha    = hist_valido ? hist_reg.linha  : '0;
   assign hist_acerto   = hist_valido & hist_reg.acerto;
   assign hist_indice   = indice_reg;
   assign cheio         = (cont_reg == CONT_MAX);
   assign total_ataques = tot_at_reg;
   assign total_acertos = tot_ac_reg;
   assign duplicado     = dup_reg;
   assign invalido      = inv_reg;

endmodule
